elastic_fifo: RTL and testbench

//   Parametrised valid/ready FIFO for CGRA processing-element and interconnect links.

---
 rtl/elastic_fifo.sv | 145 ++++++++++++++
 tb/tb_elastic_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : elastic_fifo
//  Description : Parametrised valid/ready FIFO for CGRA PE and interconnect
//                links. Configurable width and depth, optional registered
//                output stage, occupancy count with almost-full/almost-empty
//                flags, and synchronous flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module elastic_fifo #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int OUT_REG  = 0,
    parameter int AF_LEVEL = 28,
    parameter int AE_LEVEL = 2,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH + OUT_REG + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_flush,
    input  logic [DATA_W-1:0] io_din,
    input  logic              io_din_v,
    output logic              io_din_r,
    output logic [DATA_W-1:0] io_dout,
    output logic              io_dout_v,
    input  logic              io_dout_r,
    output logic [CW-1:0]     io_count,
    output logic              io_almost_full,
    output logic              io_almost_empty
);

    localparam logic [CW-1:0] c_af_level = CW'(AF_LEVEL);
    localparam logic [CW-1:0] c_ae_level = CW'(AE_LEVEL);
    localparam logic [AW:0]   c_ptr_one  = (AW+1)'(1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);

    // Storage array; deliberately not reset.
    logic [DATA_W-1:0] r_mem [DEPTH];

    // Pointers carry one extra MSB so full and empty differ only in that bit.
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic              w_st_empty;
    logic              w_st_full;
    logic              w_push;
    logic              w_pop;
    logic              w_st_rd;
    logic              w_dout_v;
    logic [DATA_W-1:0] w_dout;
    logic [DATA_W-1:0] w_rd_data;

    assign w_st_empty = (r_wr_ptr == r_rd_ptr);
    assign w_st_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_rd_data  = r_mem[r_rd_ptr[AW-1:0]];

    // Ready depends only on storage fullness, never on the consumer.
    assign w_push     = io_din_v & ~w_st_full;
    assign w_pop      = w_dout_v & io_dout_r;

    // Write a pushed word into storage; a flush-cycle push is dropped.
    always_ff @(posedge clock) begin
        if (w_push && !io_flush) begin
            r_mem[r_wr_ptr[AW-1:0]] <= io_din;
        end
    end

    // Advance read/write pointers; flush clears both.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (io_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_st_rd) r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
    end

    // Total occupancy (storage plus output stage), moved by external handshakes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (io_flush) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    generate
        if (OUT_REG == 0) begin : g_fwft
            // Head of storage is presented directly; masked to zero when empty
            // so the data bus reads as zero out of reset.
            assign w_dout_v = ~w_st_empty;
            assign w_dout   = w_st_empty ? '0 : w_rd_data;
            assign w_st_rd  = w_pop;
        end else begin : g_out_reg
            logic              r_out_v;
            logic [DATA_W-1:0] r_out_data;
            logic              w_load;

            // Refill the output stage whenever it is empty or being drained.
            assign w_load = ~w_st_empty & (~r_out_v | io_dout_r);

            // Output stage register: loads from storage head, clears on pop.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_out_v    <= 1'b0;
                    r_out_data <= '0;
                end else if (io_flush) begin
                    r_out_v    <= 1'b0;
                    r_out_data <= '0;
                end else if (w_load) begin
                    r_out_v    <= 1'b1;
                    r_out_data <= w_rd_data;
                end else if (w_pop) begin
                    r_out_v    <= 1'b0;
                end
            end

            assign w_dout_v = r_out_v;
            assign w_dout   = r_out_data;
            assign w_st_rd  = w_load;
        end
    endgenerate

    assign io_din_r        = ~w_st_full;
    assign io_dout         = w_dout;
    assign io_dout_v       = w_dout_v;
    assign io_count        = r_count;
    assign io_almost_full  = (r_count >= c_af_level);
    assign io_almost_empty = (r_count <= c_ae_level);

endmodule
`default_nettype wire

// File: tb/tb_elastic_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_elastic_fifo
//  Description : Directed self-checking bench for elastic_fifo; one instance
//                in fall-through mode, one with the registered output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_elastic_fifo;

    logic        clock;
    logic        reset;

    // Fall-through instance (OUT_REG=0)
    logic        a_flush, a_din_v, a_din_r, a_dout_v, a_dout_r, a_af, a_ae;
    logic [31:0] a_din, a_dout;
    logic [5:0]  a_count;

    // Registered-output instance (OUT_REG=1)
    logic        b_flush, b_din_v, b_din_r, b_dout_v, b_dout_r, b_af, b_ae;
    logic [31:0] b_din, b_dout;
    logic [5:0]  b_count;

    int n_checks;
    int n_pass;

    elastic_fifo #(.DATA_W(32), .DEPTH(32), .OUT_REG(0), .AF_LEVEL(28), .AE_LEVEL(2)) u_dut_a (
        .clock           (clock),
        .reset           (reset),
        .io_flush        (a_flush),
        .io_din          (a_din),
        .io_din_v        (a_din_v),
        .io_din_r        (a_din_r),
        .io_dout         (a_dout),
        .io_dout_v       (a_dout_v),
        .io_dout_r       (a_dout_r),
        .io_count        (a_count),
        .io_almost_full  (a_af),
        .io_almost_empty (a_ae)
    );

    elastic_fifo #(.DATA_W(32), .DEPTH(32), .OUT_REG(1), .AF_LEVEL(28), .AE_LEVEL(2)) u_dut_b (
        .clock           (clock),
        .reset           (reset),
        .io_flush        (b_flush),
        .io_din          (b_din),
        .io_din_v        (b_din_v),
        .io_din_r        (b_din_r),
        .io_dout         (b_dout),
        .io_dout_v       (b_dout_v),
        .io_dout_r       (b_dout_r),
        .io_count        (b_count),
        .io_almost_full  (b_af),
        .io_almost_empty (b_ae)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic a_push(input logic [31:0] d);
        a_din   = d;
        a_din_v = 1'b1;
        tick();
        a_din_v = 1'b0;
    endtask

    task automatic a_pop_expect(input string tag, input logic [31:0] d);
        check({tag, "_v"}, a_dout_v, 1'b1);
        check(tag, a_dout, d);
        a_dout_r = 1'b1;
        tick();
        a_dout_r = 1'b0;
    endtask

    initial begin
        int errs;
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b0;
        a_flush = 0; a_din_v = 0; a_dout_r = 0; a_din = '0;
        b_flush = 0; b_din_v = 0; b_dout_r = 0; b_din = '0;
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // ---- reset state ----
        check("rst_count", a_count, 0);
        check("rst_dout_v", a_dout_v, 0);
        check("rst_dout", a_dout, 0);
        check("rst_ae", a_ae, 1);
        check("rst_af", a_af, 0);
        check("rst_din_r", a_din_r, 1);
        check("rst_b_dout_v", b_dout_v, 0);

        // ---- basic ordering with back-pressure ----
        a_push(32'h11);
        a_push(32'h22);
        a_push(32'h33);
        check("t1_count", a_count, 3);
        check("t1_head", a_dout, 32'h11);
        repeat (3) tick();
        check("t1_head_hold", a_dout, 32'h11);
        check("t1_v_hold", a_dout_v, 1);
        a_pop_expect("t1_w0", 32'h11);
        a_pop_expect("t1_w1", 32'h22);
        a_pop_expect("t1_w2", 32'h33);
        check("t1_empty_v", a_dout_v, 0);
        check("t1_empty_cnt", a_count, 0);

        // ---- fill to full, refuse extra, drain ----
        for (int i = 0; i < 32; i++) begin
            a_push(32'h100 + i);
            if (i == 1) check("t2_ae_at2", a_ae, 1);
            if (i == 2) check("t2_ae_at3", a_ae, 0);
            if (i == 26) check("t2_af_at27", a_af, 0);
            if (i == 27) check("t2_af_at28", a_af, 1);
            if (i == 30) check("t2_din_r_at31", a_din_r, 1);
        end
        check("t2_count_full", a_count, 32);
        check("t2_din_r_full", a_din_r, 0);
        check("t2_af_full", a_af, 1);
        a_push(32'hDEAD);
        check("t2_refused_cnt", a_count, 32);
        errs = 0;
        for (int i = 0; i < 32; i++) begin
            if (a_dout_v !== 1'b1 || a_dout !== 32'h100 + i) errs++;
            a_dout_r = 1'b1;
            tick();
        end
        a_dout_r = 1'b0;
        check("t2_drain_errs", errs, 0);
        check("t2_drain_v", a_dout_v, 0);
        check("t2_drain_cnt", a_count, 0);

        // ---- streaming push+pop, pointers wrap ----
        a_din = 32'd0; a_din_v = 1'b1; a_dout_r = 1'b0;
        tick();
        errs = 0;
        for (int k = 1; k < 100; k++) begin
            a_din = k; a_dout_r = 1'b1;
            if (a_dout !== k - 1 || a_count !== 6'd1 || a_dout_v !== 1'b1) errs++;
            tick();
        end
        a_din_v = 1'b0; a_dout_r = 1'b0;
        check("t3_stream_errs", errs, 0);
        check("t3_count", a_count, 1);
        a_pop_expect("t3_last", 32'd99);
        check("t3_empty", a_dout_v, 0);

        // ---- flush with a concurrent push ----
        for (int i = 0; i < 5; i++) a_push(32'h200 + i);
        check("t5_count5", a_count, 5);
        a_flush = 1'b1; a_din = 32'hBAD; a_din_v = 1'b1;
        tick();
        a_flush = 1'b0; a_din_v = 1'b0;
        check("t5_count", a_count, 0);
        check("t5_dout_v", a_dout_v, 0);
        check("t5_din_r", a_din_r, 1);
        tick();
        check("t5_no_ghost", a_dout_v, 0);
        a_push(32'h77);
        check("t5_after_cnt", a_count, 1);
        a_pop_expect("t5_after", 32'h77);

        // ---- registered output stage latency and capacity ----
        b_din = 32'hA5; b_din_v = 1'b1;
        tick();
        b_din_v = 1'b0;
        check("t4_v_edgeN", b_dout_v, 0);
        check("t4_cnt_edgeN", b_count, 1);
        tick();
        check("t4_v_edgeN1", b_dout_v, 1);
        check("t4_dout", b_dout, 32'hA5);
        for (int i = 0; i < 32; i++) begin
            b_din = 32'h300 + i; b_din_v = 1'b1;
            tick();
        end
        check("t4_din_r_at33", b_din_r, 0);
        check("t4_count33", b_count, 33);
        b_din = 32'hBEEF;
        tick();
        b_din_v = 1'b0;
        check("t4_refused", b_count, 33);
        check("t4_head_hold", b_dout, 32'hA5);
        errs = 0;
        for (int i = 0; i < 33; i++) begin
            if (b_dout_v !== 1'b1 || b_dout !== (i == 0 ? 32'hA5 : 32'h300 + i - 1)) errs++;
            b_dout_r = 1'b1;
            tick();
        end
        b_dout_r = 1'b0;
        check("t4_drain_errs", errs, 0);
        check("t4_drain_cnt", b_count, 0);
        check("t4_drain_v", b_dout_v, 0);

        // ---- async reset mid-burst ----
        a_din_v = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_din = 32'h400 + i;
            tick();
        end
        #2;
        reset = 1'b0;
        #1;
        check("t6_count", a_count, 0);
        check("t6_dout_v", a_dout_v, 0);
        check("t6_dout", a_dout, 0);
        check("t6_din_r", a_din_r, 1);
        check("t6_ae", a_ae, 1);
        a_din_v = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        a_push(32'h5A);
        check("t6_post_cnt", a_count, 1);
        a_pop_expect("t6_post", 32'h5A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
